// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: host, ibus, dbus and RAM signals around the arbiter
interface ram_bus_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int LANES = DATA_W / 8;
  localparam int HA_W = ADDR_W + $clog2(LANES);
  logic cpu_hold;
  logic host_valid;
  logic host_we;
  logic [HA_W-1:0] host_addr;
  logic [7:0] host_wdata;
  logic host_ready;
  logic host_rvalid;
  logic [7:0] host_rdata;
  logic ibus_cyc;
  logic [ADDR_W-1:0] ibus_adr;
  logic [DATA_W-1:0] ibus_rdt;
  logic ibus_ack;
  logic dbus_cyc;
  logic [ADDR_W-1:0] dbus_adr;
  logic dbus_we;
  logic [DATA_W-1:0] dbus_dat;
  logic [LANES-1:0] dbus_sel;
  logic [DATA_W-1:0] dbus_rdt;
  logic dbus_ack;
  logic ram_en;
  logic [ADDR_W-1:0] ram_a;
  logic [LANES-1:0] ram_we;
  logic [DATA_W-1:0] ram_di;
  logic [DATA_W-1:0] ram_do;
  logic [1:0] grant;
  modport slave (
    input cpu_hold, host_valid, host_we, host_addr, host_wdata,
    input ibus_cyc, ibus_adr, dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel, ram_do,
    output host_ready, host_rvalid, host_rdata, ibus_rdt, ibus_ack, dbus_rdt, dbus_ack,
    output ram_en, ram_a, ram_we, ram_di, grant
  );
  modport master (
    output cpu_hold, host_valid, host_we, host_addr, host_wdata,
    output ibus_cyc, ibus_adr, dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel, ram_do,
    input host_ready, host_rvalid, host_rdata, ibus_rdt, ibus_ack, dbus_rdt, dbus_ack,
    input ram_en, ram_a, ram_we, ram_di, grant
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one byte-write single-port RAM between host, SERV dbus and ibus
// with a fixed arbitrate / issue / respond sequence.
module ram_bus_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int HOST_PRIO = 1
) (
  input logic clk,
  input logic rst_n,
  ram_bus_arbiter_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB = $clog2(LANES);
  localparam int HA_W = ADDR_W + LB;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state_q;
  logic [1:0] grant_q;
  logic ram_en_q;
  logic [LANES-1:0] ram_we_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [DATA_W-1:0] ram_di_q;
  logic [LB-1:0] lane_q;
  logic hrd_q;
  logic host_rvalid_q;
  logic ibus_ack_q;
  logic dbus_ack_q;
  logic h_el, d_el, i_el;
  logic [1:0] owner_d;
  logic [LANES-1:0] we_d;
  logic [DATA_W-1:0] di_d;
  logic [ADDR_W-1:0] addr_d;
  assign h_el = bus.host_valid;
  assign d_el = bus.dbus_cyc & ~bus.cpu_hold;
  assign i_el = bus.ibus_cyc & ~bus.cpu_hold;
  // owner codes match the grant encoding: 1 host, 2 dbus, 3 ibus
  always_comb begin
    owner_d = (HOST_PRIO != 0) ? (h_el ? 2'd1 : d_el ? 2'd2 : i_el ? 2'd3 : 2'd0)
                               : (d_el ? 2'd2 : i_el ? 2'd3 : h_el ? 2'd1 : 2'd0);
    we_d = (owner_d == 2'd1) ? (bus.host_we ? LANES'(1) << bus.host_addr[LB-1:0] : '0)
         : (owner_d == 2'd2 && bus.dbus_we) ? bus.dbus_sel : '0;
    di_d = (owner_d == 2'd1) ? {LANES{bus.host_wdata}} : bus.dbus_dat;
    addr_d = (owner_d == 2'd1) ? bus.host_addr[HA_W-1:LB]
           : (owner_d == 2'd2) ? bus.dbus_adr : bus.ibus_adr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= '0;
      ram_a_q <= '0;
      ram_di_q <= '0;
      lane_q <= '0;
      hrd_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (owner_d != 2'd0) begin
          state_q <= ISSUE;
          grant_q <= owner_d;
          ram_en_q <= 1'b1;
          ram_we_q <= we_d;
          ram_a_q <= addr_d;
          ram_di_q <= di_d;
          lane_q <= bus.host_addr[LB-1:0];
          hrd_q <= (owner_d == 2'd1) && !bus.host_we;
        end
        ISSUE: begin
          state_q <= RESP;
          ram_en_q <= 1'b0;
          ram_we_q <= '0;
          host_rvalid_q <= hrd_q;
          dbus_ack_q <= (grant_q == 2'd2);
          ibus_ack_q <= (grant_q == 2'd3);
        end
        RESP: begin
          state_q <= IDLE;
          grant_q <= '0;
          host_rvalid_q <= 1'b0;
          dbus_ack_q <= 1'b0;
          ibus_ack_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.host_ready = (state_q == IDLE) && (owner_d == 2'd1);
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata = bus.ram_do[8*lane_q +: 8];
  assign bus.ibus_rdt = bus.ram_do;
  assign bus.ibus_ack = ibus_ack_q;
  assign bus.dbus_rdt = bus.ram_do;
  assign bus.dbus_ack = dbus_ack_q;
  assign bus.ram_en = ram_en_q;
  assign bus.ram_a = ram_a_q;
  assign bus.ram_we = ram_we_q;
  assign bus.ram_di = ram_di_q;
  assign bus.grant = grant_q;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed vector bench for ram_bus_arbiter with a behavioural RAM32 model
module tb_ram_bus_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ram_bus_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b0();
  ram_bus_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b1();
  ram_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .HOST_PRIO(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  ram_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .HOST_PRIO(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic [DW-1:0] m0 [2**AW];
  logic [DW-1:0] m1 [2**AW];
  always @(posedge clk) if (b0.ram_en) begin
    for (int i = 0; i < 4; i++) if (b0.ram_we[i]) m0[b0.ram_a][8*i +: 8] <= b0.ram_di[8*i +: 8];
    b0.ram_do <= m0[b0.ram_a];
  end
  always @(posedge clk) if (b1.ram_en) begin
    for (int i = 0; i < 4; i++) if (b1.ram_we[i]) m1[b1.ram_a][8*i +: 8] <= b1.ram_di[8*i +: 8];
    b1.ram_do <= m1[b1.ram_a];
  end
  logic pv = 1'b0, pd = 1'b0, pi = 1'b0;
  assign b1.cpu_hold = 1'b0;
  assign b1.host_valid = pv;
  assign b1.host_we = 1'b0;
  assign b1.host_addr = '0;
  assign b1.host_wdata = '0;
  assign b1.dbus_cyc = pd;
  assign b1.dbus_adr = 5'd1;
  assign b1.dbus_we = 1'b0;
  assign b1.dbus_dat = '0;
  assign b1.dbus_sel = '0;
  assign b1.ibus_cyc = pi;
  assign b1.ibus_adr = 5'd2;
  typedef struct {
    logic [1:0] src;
    logic we;
    logic [6:0] adr;
    logic [31:0] dat;
    logic [3:0] sel;
    logic [3:0] xwe;
    logic [31:0] xrd;
  } vec_t;
  vec_t vt [16];
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic access(input vec_t v);
    @(negedge clk);
    b0.cpu_hold = (v.src == 2'd1);
    b0.host_valid = (v.src == 2'd1);
    b0.host_we = v.we;
    b0.host_addr = v.adr;
    b0.host_wdata = v.dat[7:0];
    b0.dbus_cyc = (v.src == 2'd2);
    b0.dbus_we = v.we;
    b0.dbus_adr = v.adr[4:0];
    b0.dbus_dat = v.dat;
    b0.dbus_sel = v.sel;
    b0.ibus_cyc = (v.src == 2'd3);
    b0.ibus_adr = v.adr[4:0];
    #1 chk("host_ready", b0.host_ready, v.src == 2'd1);
    chk("idle_grant", b0.grant, 0);
    @(negedge clk);
    b0.host_valid = 1'b0;
    b0.dbus_cyc = 1'b0;
    b0.ibus_cyc = 1'b0;
    chk("issue_en", b0.ram_en, 1);
    chk("issue_we", b0.ram_we, v.xwe);
    chk("issue_a", b0.ram_a, (v.src == 2'd1) ? v.adr[6:2] : v.adr[4:0]);
    chk("issue_grant", b0.grant, v.src);
    if (v.we) chk("issue_di", b0.ram_di, (v.src == 2'd1) ? {4{v.dat[7:0]}} : v.dat);
    @(negedge clk);
    chk("resp_en", b0.ram_en, 0);
    chk("resp_we", b0.ram_we, 0);
    if (v.src == 2'd1) begin
      chk("host_rvalid", b0.host_rvalid, !v.we);
      if (!v.we) chk("host_rdata", b0.host_rdata, v.xrd);
    end else if (v.src == 2'd2) begin
      chk("dbus_ack", b0.dbus_ack, 1);
      if (!v.we) chk("dbus_rdt", b0.dbus_rdt, v.xrd);
    end else begin
      chk("ibus_ack", b0.ibus_ack, 1);
      chk("ibus_rdt", b0.ibus_rdt, v.xrd);
    end
  endtask
  logic [1:0] exp_ord [3];
  initial begin
    vt[0]  = '{2'd1, 1'b1, 7'd0,   32'h11,        4'h0, 4'b0001, 32'h0};
    vt[1]  = '{2'd1, 1'b1, 7'd1,   32'h22,        4'h0, 4'b0010, 32'h0};
    vt[2]  = '{2'd1, 1'b1, 7'd2,   32'h33,        4'h0, 4'b0100, 32'h0};
    vt[3]  = '{2'd1, 1'b1, 7'd3,   32'h44,        4'h0, 4'b1000, 32'h0};
    vt[4]  = '{2'd1, 1'b0, 7'd2,   32'h0,         4'h0, 4'b0000, 32'h33};
    vt[5]  = '{2'd2, 1'b1, 7'd5,   32'hDEADBEEF,  4'hF, 4'b1111, 32'h0};
    vt[6]  = '{2'd3, 1'b0, 7'd5,   32'h0,         4'h0, 4'b0000, 32'hDEADBEEF};
    vt[7]  = '{2'd2, 1'b1, 7'd7,   32'h0,         4'hF, 4'b1111, 32'h0};
    vt[8]  = '{2'd2, 1'b1, 7'd7,   32'hAABBCCDD,  4'h6, 4'b0110, 32'h0};
    vt[9]  = '{2'd2, 1'b0, 7'd7,   32'h0,         4'h0, 4'b0000, 32'h00BBCC00};
    vt[10] = '{2'd2, 1'b1, 7'd7,   32'hFFFFFFFF,  4'h0, 4'b0000, 32'h0};
    vt[11] = '{2'd2, 1'b0, 7'd7,   32'h0,         4'h0, 4'b0000, 32'h00BBCC00};
    vt[12] = '{2'd1, 1'b0, 7'd29,  32'h0,         4'h0, 4'b0000, 32'hCC};
    vt[13] = '{2'd3, 1'b0, 7'd0,   32'h0,         4'h0, 4'b0000, 32'h44332211};
    vt[14] = '{2'd1, 1'b1, 7'h7F,  32'h5A,        4'h0, 4'b1000, 32'h0};
    vt[15] = '{2'd1, 1'b0, 7'h7F,  32'h0,         4'h0, 4'b0000, 32'h5A};
    b0.cpu_hold = 1'b1;
    b0.host_valid = 1'b0;
    b0.host_we = 1'b0;
    b0.host_addr = '0;
    b0.host_wdata = '0;
    b0.dbus_cyc = 1'b0;
    b0.dbus_we = 1'b0;
    b0.dbus_adr = '0;
    b0.dbus_dat = '0;
    b0.dbus_sel = '0;
    b0.ibus_cyc = 1'b0;
    b0.ibus_adr = '0;
    repeat (2) @(negedge clk);
    chk("rst_en", b0.ram_en, 0);
    chk("rst_we", b0.ram_we, 0);
    chk("rst_a", b0.ram_a, 0);
    chk("rst_di", b0.ram_di, 0);
    chk("rst_grant", b0.grant, 0);
    chk("rst_ready", b0.host_ready, 0);
    chk("rst_rvalid", b0.host_rvalid, 0);
    chk("rst_iack", b0.ibus_ack, 0);
    chk("rst_dack", b0.dbus_ack, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) access(vt[k]);
    // ibus held off by cpu_hold, then hold rises again while its access is in flight
    @(negedge clk);
    b0.cpu_hold = 1'b1;
    b0.ibus_cyc = 1'b1;
    b0.ibus_adr = 5'd5;
    repeat (5) begin
      @(negedge clk);
      chk("hold_grant", b0.grant, 0);
      chk("hold_ack", b0.ibus_ack, 0);
    end
    b0.cpu_hold = 1'b0;
    @(negedge clk);
    chk("unhold_grant", b0.grant, 3);
    chk("unhold_en", b0.ram_en, 1);
    b0.ibus_cyc = 1'b0;
    b0.cpu_hold = 1'b1;
    @(negedge clk);
    chk("unhold_ack", b0.ibus_ack, 1);
    chk("unhold_rdt", b0.ibus_rdt, 32'hDEADBEEF);
    // reset asserted during ISSUE of a host read
    @(negedge clk);
    b0.host_valid = 1'b1;
    b0.host_we = 1'b0;
    b0.host_addr = 7'd2;
    @(negedge clk);
    b0.host_valid = 1'b0;
    chk("mid_en", b0.ram_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_en", b0.ram_en, 0);
    chk("abort_grant", b0.grant, 0);
    @(negedge clk);
    chk("abort_rvalid", b0.host_rvalid, 0);
    rst_n = 1'b1;
    access(vt[4]);
    // simultaneous requests, HOST_PRIO = 1
    exp_ord = '{2'd1, 2'd2, 2'd3};
    @(negedge clk);
    b0.cpu_hold = 1'b0;
    b0.host_valid = 1'b1;
    b0.host_we = 1'b0;
    b0.host_addr = 7'd0;
    b0.dbus_cyc = 1'b1;
    b0.dbus_we = 1'b0;
    b0.dbus_adr = 5'd7;
    b0.ibus_cyc = 1'b1;
    b0.ibus_adr = 5'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prio1_grant", b0.grant, exp_ord[k]);
      if (b0.grant == 2'd1) b0.host_valid = 1'b0;
      if (b0.grant == 2'd2) b0.dbus_cyc = 1'b0;
      if (b0.grant == 2'd3) b0.ibus_cyc = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    b0.host_valid = 1'b0;
    b0.dbus_cyc = 1'b0;
    b0.ibus_cyc = 1'b0;
    // simultaneous requests, HOST_PRIO = 0
    exp_ord = '{2'd2, 2'd3, 2'd1};
    pv = 1'b1;
    pd = 1'b1;
    pi = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prio0_grant", b1.grant, exp_ord[k]);
      if (b1.grant == 2'd1) pv = 1'b0;
      if (b1.grant == 2'd2) pd = 1'b0;
      if (b1.grant == 2'd3) pi = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    pv = 1'b0;
    pd = 1'b0;
    pi = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
Parametrised arbiter between a byte-wide host load/debug port and the SERV instruction and data Wishbone buses, all sharing one single-port synchronous RAM macro with per-byte write enables (RAM32-style EN/A/WE/Di/Do). It replaces direct host-pin RAM access: the host can load program memory while the CPU is held off, then inspect memory while the CPU runs. Fixed three-cycle access: arbitrate, issue, respond.

Parameters:
DATA_W, 32, RAM word width in bits; multiple of 8; LANES = DATA_W/8.
ADDR_W, 5, RAM word-address width.
HOST_PRIO, 1, 1: host > dbus > ibus; 0: dbus > ibus > host.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cpu_hold  in  1  1 = CPU requests not granted; host only
host_valid  in  1  host request
host_we  in  1  1 = byte write, 0 = byte read
host_addr  in  ADDR_W+log2(LANES)  byte address; low log2(LANES) bits = lane
host_wdata  in  8  write byte
host_ready  out  1  request accepted this cycle
host_rvalid  out  1  one-cycle pulse, host_rdata valid
host_rdata  out  8  read byte
ibus_cyc  in  1  instruction fetch request
ibus_adr  in  ADDR_W  word address
ibus_rdt  out  DATA_W  fetch data, valid with ibus_ack
ibus_ack  out  1  one-cycle acknowledge
dbus_cyc  in  1  data request
dbus_adr  in  ADDR_W  word address
dbus_we  in  1  1 = write
dbus_dat  in  DATA_W  write data
dbus_sel  in  LANES  byte enables
dbus_rdt  out  DATA_W  read data, valid with dbus_ack
dbus_ack  out  1  one-cycle acknowledge
ram_en  out  1  RAM enable
ram_a  out  ADDR_W  RAM word address
ram_we  out  LANES  RAM byte write enables
ram_di  out  DATA_W  RAM write data
ram_do  in  DATA_W  RAM read data, valid the cycle after ram_en
grant  out  2  current owner: 0 none, 1 host, 2 dbus, 3 ibus

Behaviour:
- FSM states IDLE, ISSUE, RESP. Reset (async, rst_n low) -> IDLE; all registers 0; ram_en, ram_we, ram_a, ram_di, grant, host_ready, host_rvalid, ibus_ack, dbus_ack all 0.
- IDLE: sample requests. Eligible: host_valid; dbus_cyc and ibus_cyc only when cpu_hold = 0. Pick the winner per HOST_PRIO. Latch owner, address, we, data and lane mask. host_ready = 1 combinationally in IDLE iff host wins. Go to ISSUE; with no winner stay in IDLE.
- ISSUE: ram_en = 1, ram_a = latched address.
  - Host write: ram_we = one-hot(lane), ram_di = wdata replicated on all lanes.
  - dbus write: ram_we = latched sel, ram_di = latched dat.
  - Reads: ram_we = 0. -> RESP.
- RESP: ram_en = 0, ram_we = 0.
  - CPU owner: its ack = 1 for exactly this cycle, reads and writes alike.
  - Host read: host_rvalid = 1, host_rdata = ram_do[8*lane +: 8] using the latched lane.
  - Host write: no rvalid pulse.
  - -> IDLE; grant returns to 0 in IDLE.
- ibus_rdt and dbus_rdt are driven combinationally from ram_do; their content is only meaningful while the matching ack is high.
- Latency: request sampled in IDLE at cycle N; RAM enabled at N+1; ack/rvalid at N+2; next arbitration at N+3. Throughput is one access per 3 cycles.
- A CPU master must drop cyc in the cycle after ack. If cyc is still high in IDLE, it is a new request.
- dbus write with sel = 0: ram_en pulses, ram_we = 0, ack still given.
- cpu_hold rising while a CPU access is in ISSUE/RESP: that access completes normally; the hold takes effect at the next IDLE.
- Host and CPU changes after acceptance do not affect an access in flight, since everything is latched.
- Address wrap: ram_a is the ADDR_W-bit address as given; no range check.
- Reset mid-access: aborts immediately. No ack/rvalid is produced and ram_en/ram_we drop asynchronously.

Test Plan:
- Host load, then read: cpu_hold = 1; write bytes 0x11, 0x22, 0x33, 0x44 to host_addr 0..3. ram_we sequence is 0001, 0010, 0100, 1000 with ram_a = 0. Read host_addr 2 -> host_rvalid two cycles after host_ready, host_rdata = 0x33.
- CPU fetch: cpu_hold = 0, ibus_cyc with ibus_adr = 5, word preloaded 0xDEADBEEF -> ram_en at N+1, ibus_ack at N+2 with ibus_rdt = 0xDEADBEEF, grant = 3 during access.
- Simultaneous host_valid, dbus_cyc and ibus_cyc with HOST_PRIO = 1 -> served host, dbus, ibus on cycles N, N+3, N+6. With HOST_PRIO = 0 -> dbus, ibus, host.
- dbus write dat = 0xAABBCCDD, sel = 0110 to a word holding 0 -> readback 0x00BBCC00. Write with sel = 0000 still gives dbus_ack and leaves the word unchanged.
- cpu_hold = 1 with ibus_cyc held high -> no ibus_ack and grant stays 0 until hold clears; then ack arrives 2 cycles after the first IDLE sample.
- Assert rst_n low during ISSUE of a host read -> ram_en and outputs go 0 immediately, no host_rvalid. After release, FSM is in IDLE and the next request completes normally.
